// File: rtl/upg_pkg.sv
// upg_loader shared types: FSM states and target codes
// of the UART programming frame.
package upg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE
  } upg_state_e;

  localparam logic [7:0] TGT_ROM = 8'h00;
  localparam logic [7:0] TGT_RAM = 8'h01;
  localparam logic [7:0] TGT_END = 8'hFF;

endpackage

// File: rtl/upg_word_assembler.sv
// Little-endian byte-to-word assembler for upg_loader.
// word_o carries the word including the byte being loaded.
module upg_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] sreg_q, sreg_d;

  // place the incoming byte into its lane and advance the lane counter
  always_comb begin
    cnt_d  = cnt_q;
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d[8*cnt_q +: 8] = byte_i;
      cnt_d                = cnt_q + 2'd1;
    end
    if (clr_i) begin
      cnt_d  = 2'd0;
      sreg_d = 32'h0;
    end
  end

  assign word_o      = sreg_d;
  assign word_full_o = load_i & (cnt_q == 2'd3);

  // lane counter and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      sreg_q <= 32'h0;
    end else begin
      cnt_q  <= cnt_d;
      sreg_q <= sreg_d;
    end
  end

endmodule

// File: rtl/upg_loader.sv
// UART programming sequencer: frames bytes into ROM/RAM word writes.
// Optional inter-byte timeout enabled by defining UPG_TIMEOUT_EN.
module upg_loader
  import upg_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic            upg_clk_i,
  input  logic            upg_rst_n_i,
  input  logic            rx_valid_i,
  input  logic [7:0]      rx_data_i,
  output logic            rx_ready_o,
  output logic            upg_wen_o,
  output logic [ADDR_W:0] upg_adr_o,
  output logic [31:0]     upg_dat_o,
  output logic            upg_done_o,
  output logic            upg_err_o
);

  upg_state_e state_q, state_d;

  logic [15:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic            tgt_q, tgt_d;
  logic            ready_q, ready_d;
  logic            wen_q, wen_d;
  logic [ADDR_W:0] adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic        accept;
  logic [15:0] len_w;
  logic        len_big;
  logic        asm_clr;
  logic        asm_load;
  logic [31:0] asm_word;
  logic        asm_full;
  logic        tmo_hit;

  assign accept  = rx_valid_i & ready_q;
  assign len_w   = {rx_data_i, cnt_q[7:0]};
  assign len_big = {16'h0, len_w} > (32'd1 << ADDR_W);

  upg_word_assembler u_asm (
    .clk         (upg_clk_i),
    .rst_n       (upg_rst_n_i),
    .clr_i       (asm_clr),
    .load_i      (asm_load),
    .byte_i      (rx_data_i),
    .word_o      (asm_word),
    .word_full_o (asm_full)
  );

`ifdef UPG_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;

  // inter-byte gap counter, live only while a frame is open
  always_comb begin
    tmo_d   = 32'h0;
    tmo_hit = 1'b0;
    if (state_q == S_LEN_LO ||
        state_q == S_LEN_HI ||
        state_q == S_DATA) begin
      if (accept) begin
        tmo_d = 32'h0;
      end else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
        tmo_hit = 1'b1;
      end else begin
        tmo_d = tmo_q + 32'h1;
      end
    end
  end

  // gap counter register
  always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
    if (!upg_rst_n_i) tmo_q <= 32'h0;
    else              tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  // frame parser: next state, write strobe, error and done
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    tgt_d    = tgt_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    wen_d    = 1'b0;
    err_d    = 1'b0;
    done_d   = done_q;
    asm_clr  = 1'b0;
    asm_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            (rx_data_i == TGT_ROM),
            (rx_data_i == TGT_RAM): begin
              tgt_d   = rx_data_i[0];
              state_d = S_LEN_LO;
            end
            (rx_data_i == TGT_END): begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          cnt_d   = {8'h00, rx_data_i};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          cnt_d = len_w;
          if (len_w == 16'h0) begin
            state_d = S_IDLE;
          end else if (len_big) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            addr_d  = '0;
            asm_clr = 1'b1;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          asm_load = 1'b1;
          if (asm_full) begin
            wen_d   = 1'b1;
            adr_d   = {tgt_q, addr_q};
            dat_d   = asm_word;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 16'h1;
        state_d = (cnt_q != 16'h1) ? S_DATA : S_IDLE;
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) begin
      err_d   = 1'b1;
      asm_clr = 1'b1;
      state_d = S_IDLE;
    end
  end

  assign ready_d = (state_d != S_WRITE) &&
                   (state_d != S_DONE);

  // state and registered outputs
  always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
    if (!upg_rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'h0;
      addr_q  <= '0;
      tgt_q   <= 1'b0;
      ready_q <= 1'b0;
      wen_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= 32'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
      ready_q <= ready_d;
      wen_q   <= wen_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rx_ready_o = ready_q;
  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign upg_err_o  = err_q;

endmodule

// File: doc/upg_loader.md
# upg_loader

Byte-stream sequencer that drives the UART programming port of the program ROM and data memory. It consumes bytes from the UART receiver and assembles little-endian 32-bit words. It issues one-cycle write strobes with incrementing word addresses and raises a sticky done flag that hands the memories back to the CPU. It sits between the UART RX core and the ROM/RAM programming muxes, in the UART clock domain.

## Interface
Parameters:
- ADDR_W, 14, word-address width per memory
- TIMEOUT_CYCLES, 1_000_000, inter-byte timeout in clock cycles (used only with UPG_TIMEOUT_EN)

Ports:
- upg_clk_i  in  1  UART-domain clock (10 MHz); single clock of the block
- upg_rst_n_i  in  1  reset, asynchronous, active-low
- rx_valid_i  in  1  received byte valid
- rx_data_i  in  8  received byte
- rx_ready_o  out  1  byte accepted when rx_valid_i & rx_ready_o
- upg_wen_o  out  1  write strobe, one cycle per word
- upg_adr_o  out  ADDR_W+1  {target select, word address}; MSB 0 = program ROM, 1 = data RAM
- upg_dat_o  out  32  write data
- upg_done_o  out  1  session finished, sticky until reset
- upg_err_o  out  1  one-cycle pulse on protocol error or timeout

## Operation
- Frame: target byte, count low byte, count high byte (N, 16 bit), then 4·N data bytes, least-significant byte first.
- Target codes:
  - 0x00: ROM.
  - 0x01: RAM.
  - 0xFF: end of session, enter DONE.
  - Any other value: pulse upg_err_o and stay in IDLE.
- States:
  - IDLE: wait for target byte.
  - LEN_LO, LEN_HI: capture N.
  - DATA: collect 4 bytes.
  - WRITE: one cycle.
  - DONE.
- LEN_HI transitions:
  - N = 0: return to IDLE, no write.
  - N > 2^ADDR_W: pulse upg_err_o, go to IDLE, no write.
  - Otherwise: clear word address to 0 and go to DATA.
- DATA: the 4th accepted byte moves to WRITE.
- WRITE:
  - upg_wen_o=1 with the current address and assembled word.
  - Address increments by 1.
  - Remaining count decrements by 1.
  - Next state is DATA if the count is still nonzero, else IDLE.
- Address arithmetic is ADDR_W bits. The count check guarantees no wrap within a frame.
- DONE: upg_done_o=1 and rx_ready_o=0. Only reset leaves DONE.
- Multiple frames per session are legal. Each frame restarts at address 0 of its target.

## Timing
- Reset values:
  - rx_ready_o=0. It goes to 1 in the first cycle after reset release.
  - upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, upg_err_o=0.
  - State = IDLE.
- rx_ready_o is 1 in IDLE, LEN_LO, LEN_HI and DATA. It is 0 in WRITE and DONE.
- Write latency: upg_wen_o is asserted in the cycle after the 4th data byte is accepted.
- upg_adr_o and upg_dat_o are registered and stable during the strobe cycle. They hold their values after the strobe.
- Back-to-back bytes with rx_valid_i held high: a word costs 5 cycles (4 accept + 1 WRITE).
- upg_err_o is registered and asserted in the cycle after the offending byte is accepted.
- upg_done_o rises in the cycle after 0xFF is accepted in IDLE.
- Reset asserted mid-frame: immediate return to IDLE. Any partial word is discarded and no strobe is issued.

## Configuration
- UPG_TIMEOUT_EN defined:
  - A counter clears on every accepted byte and runs in LEN_LO, LEN_HI and DATA.
  - On reaching TIMEOUT_CYCLES-1 it pulses upg_err_o and returns to IDLE. The partial word is dropped and no strobe is issued.
- UPG_TIMEOUT_EN undefined:
  - No counter is built; the block waits indefinitely.
  - TIMEOUT_CYCLES is ignored.

## Structure
- Package upg_pkg:
  - State enum.
  - Target codes TGT_ROM=8'h00, TGT_RAM=8'h01, TGT_END=8'hFF.
- Sub-module upg_word_assembler:
  - 2-bit byte counter plus 32-bit shift register.
  - Loads byte k into bits [8k+7:8k].
  - Flags word_full when the 4th byte is accepted.
  - Cleared by the FSM on frame start and on timeout.

## Test plan
- Stream 00 02 00 11 22 33 44 AA BB CC DD -> two strobes: adr 0x0000 dat 0x44332211, then adr 0x0001 dat 0xDDCCBBAA; state returns to IDLE.
- Stream 01 01 00 EF BE AD DE then FF -> one strobe adr 0x4000 dat 0xDEADBEEF; upg_done_o=1 one cycle after FF and held; rx_ready_o=0.
- Target byte 0x07 -> upg_err_o pulse, no strobe; a following 00 01 00 + 4 bytes writes normally at adr 0.
- Count 00 00 then count 0x4001 (> 2^14) -> no strobes; the second case pulses upg_err_o.
- Reset asserted after 2 data bytes, then a full 1-word frame sent -> no strobe before reset; after reset the word lands at adr 0 with correct data.
- With UPG_TIMEOUT_EN and TIMEOUT_CYCLES=16, a gap of 20 cycles after 2 data bytes -> upg_err_o pulse, no strobe; without the macro, the same gap followed by 2 more bytes gives a normal strobe.
